// File: rtl/sudoku_board_checker.sv
// Sequential Sudoku answer checker: snapshots the board on start, scans one cell
// per clock in row-major order, and reports wrong/empty counts plus the first wrong cell.
module sudoku_board_checker #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int CW = $clog2(N*N+1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             start,
  input  logic [N-1:0][N-1:0][W-1:0]       user_board,
  input  logic [N-1:0][N-1:0]              user_filled,
  input  logic [N-1:0][N-1:0][W-1:0]       key_board,
  input  logic [N-1:0][N-1:0]              given_mask,
  output logic                             busy,
  output logic                             result_valid,
  output logic                             incorrect_match,
  output logic [CW-1:0]                    wrong_count,
  output logic [CW-1:0]                    empty_count,
  output logic                             first_wrong_valid,
  output logic [$clog2(N)-1:0]             first_wrong_row,
  output logic [$clog2(N)-1:0]             first_wrong_col
);

  localparam int IW = $clog2(N*N);
  localparam int RW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N*N-1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, next_state;
  logic [IW-1:0] idx;
  logic          start_accept;
  logic [RW-1:0] cur_row, cur_col;
  logic          cell_given, cell_filled, cell_wrong;

  logic [N-1:0][N-1:0][W-1:0] snap_user, snap_key;
  logic [N-1:0][N-1:0]        snap_filled, snap_given;

  always_ff @(posedge clk) begin
    if (reset || clear) state <= IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SCAN;
      SCAN:    if (idx == LAST_IDX) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == SCAN);
    start_accept = (state == IDLE) && start;
  end

  // Row-major decode of the scan index into grid coordinates.
  always_comb begin
    cur_row     = RW'(idx / IW'(N));
    cur_col     = RW'(idx % IW'(N));
    cell_given  = snap_given[cur_row][cur_col];
    cell_filled = snap_filled[cur_row][cur_col];
    cell_wrong  = !cell_given && cell_filled &&
                  (snap_user[cur_row][cur_col] != snap_key[cur_row][cur_col]);
  end

  // NOTE: the snapshot is pure storage and is always loaded before it is read,
  // so it carries no reset; this keeps the wide board registers free of reset fan-out.
  always_ff @(posedge clk) begin
    if (start_accept) begin
      snap_user   <= user_board;
      snap_key    <= key_board;
      snap_filled <= user_filled;
      snap_given  <= given_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx               <= '0;
      result_valid      <= 1'b0;
      incorrect_match   <= 1'b0;
      wrong_count       <= '0;
      empty_count       <= '0;
      first_wrong_valid <= 1'b0;
      first_wrong_row   <= '0;
      first_wrong_col   <= '0;
    end else begin
      result_valid <= 1'b0;
      if (start_accept) begin
        idx               <= '0;
        incorrect_match   <= 1'b0;
        wrong_count       <= '0;
        empty_count       <= '0;
        first_wrong_valid <= 1'b0;
      end
      if (state == SCAN) begin
        if (!cell_given && !cell_filled) empty_count <= empty_count + CW'(1);
        if (cell_wrong) begin
          wrong_count <= wrong_count + CW'(1);
          if (!first_wrong_valid) begin
            first_wrong_valid <= 1'b1;
            first_wrong_row   <= cur_row;
            first_wrong_col   <= cur_col;
          end
        end
        idx <= idx + IW'(1);
      end
      // Flag and pulse are registered together so they appear in the same cycle.
      if (state == DONE) begin
        result_valid    <= 1'b1;
        incorrect_match <= (wrong_count != '0) || (empty_count != '0);
      end
    end
  end

endmodule

// File: tb/tb_sudoku_board_checker.sv
// Directed self-checking bench for sudoku_board_checker (N=4, W=2).
module tb_sudoku_board_checker;

  logic clk, reset, clear, start;
  logic [3:0][3:0][1:0] user_board, key_board;
  logic [3:0][3:0]      user_filled, given_mask;
  logic       busy, result_valid, incorrect_match, first_wrong_valid;
  logic [4:0] wrong_count, empty_count;
  logic [1:0] first_wrong_row, first_wrong_col;

  int checks = 0;
  int failures = 0;

  sudoku_board_checker dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .user_board(user_board), .user_filled(user_filled),
    .key_board(key_board), .given_mask(given_mask),
    .busy(busy), .result_valid(result_valid), .incorrect_match(incorrect_match),
    .wrong_count(wrong_count), .empty_count(empty_count),
    .first_wrong_valid(first_wrong_valid),
    .first_wrong_row(first_wrong_row), .first_wrong_col(first_wrong_col)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Valid 4x4 solution; stored values are digit-1.
  task automatic load_key();
    int rows[4][4] = '{'{0,1,2,3}, '{2,3,0,1}, '{1,0,3,2}, '{3,2,1,0}};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        key_board[r][c] = 2'(rows[r][c]);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the number of edges after the start edge until result_valid, or -1.
  task automatic wait_result(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; start = 1'b0;
    load_key();
    user_board = key_board; user_filled = '1; given_mask = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    checks++;
    if ({incorrect_match, wrong_count, empty_count, first_wrong_valid, first_wrong_row, first_wrong_col} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: im=%b wc=%0d ec=%0d fwv=%b row=%0d col=%0d want all 0",
               incorrect_match, wrong_count, empty_count, first_wrong_valid, first_wrong_row, first_wrong_col);
    end
  endtask

  task automatic test_all_correct();
    int cyc;
    bit busy_ok = 1;
    user_board = key_board; user_filled = '1; given_mask = '0;
    pulse_start();
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i < 16 && busy !== 1'b1) busy_ok = 0;
      if (result_valid) begin cyc = i; break; end
    end
    checks++; if (!busy_ok) begin failures++; $display("FAIL correct_busy: busy dropped during scan, want 1"); end
    checks++; if (cyc !== 17) begin failures++; $display("FAIL correct_latency: got %0d want 17", cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL correct_busy_done: got %b want 0", busy); end
    checks++; if (incorrect_match !== 1'b0) begin failures++; $display("FAIL correct_im: got %b want 0", incorrect_match); end
    checks++; if (wrong_count !== 5'd0) begin failures++; $display("FAIL correct_wc: got %0d want 0", wrong_count); end
    checks++; if (empty_count !== 5'd0) begin failures++; $display("FAIL correct_ec: got %0d want 0", empty_count); end
    checks++; if (first_wrong_valid !== 1'b0) begin failures++; $display("FAIL correct_fwv: got %b want 0", first_wrong_valid); end
    @(posedge clk); #1;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL correct_pulse_width: got %b want 0", result_valid); end
  endtask

  task automatic set_two_wrong();
    user_board = key_board;
    user_board[1][2] = key_board[1][2] + 2'd1;
    user_board[3][0] = key_board[3][0] + 2'd1;
    user_filled = '1; given_mask = '0;
  endtask

  task automatic test_two_wrong();
    int cyc;
    set_two_wrong();
    pulse_start();
    wait_result(cyc);
    checks++; if (cyc !== 17) begin failures++; $display("FAIL wrong_latency: got %0d want 17", cyc); end
    checks++; if (wrong_count !== 5'd2) begin failures++; $display("FAIL wrong_wc: got %0d want 2", wrong_count); end
    checks++; if (empty_count !== 5'd0) begin failures++; $display("FAIL wrong_ec: got %0d want 0", empty_count); end
    checks++; if (incorrect_match !== 1'b1) begin failures++; $display("FAIL wrong_im: got %b want 1", incorrect_match); end
    checks++; if (first_wrong_valid !== 1'b1) begin failures++; $display("FAIL wrong_fwv: got %b want 1", first_wrong_valid); end
    checks++;
    if (first_wrong_row !== 2'd1 || first_wrong_col !== 2'd2) begin
      failures++; $display("FAIL wrong_pos: got (%0d,%0d) want (1,2)", first_wrong_row, first_wrong_col);
    end
    // Held in IDLE after the pulse.
    repeat (3) @(posedge clk); #1;
    checks++; if (wrong_count !== 5'd2 || incorrect_match !== 1'b1) begin
      failures++; $display("FAIL wrong_hold: got wc=%0d im=%b want wc=2 im=1", wrong_count, incorrect_match);
    end
  endtask

  task automatic test_back_to_back();
    int first_cyc = -1;
    int pulses = 0;
    user_board = key_board; user_filled = '1; given_mask = '0;
    pulse_start();
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) user_board = ~key_board;
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
      if (result_valid) begin
        pulses++;
        if (first_cyc < 0) first_cyc = i;
      end
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    checks++; if (first_cyc !== 17) begin failures++; $display("FAIL b2b_latency: got %0d want 17", first_cyc); end
    checks++; if (wrong_count !== 5'd0 || incorrect_match !== 1'b0) begin
      failures++; $display("FAIL b2b_snapshot: got wc=%0d im=%b want wc=0 im=0", wrong_count, incorrect_match);
    end
  endtask

  task automatic test_all_empty();
    int cyc;
    user_board = key_board; user_filled = '0;
    given_mask = '0;
    given_mask[0][0] = 1'b1; given_mask[1][1] = 1'b1; given_mask[2][2] = 1'b1;
    given_mask[3][3] = 1'b1; given_mask[0][3] = 1'b1; given_mask[3][0] = 1'b1;
    pulse_start();
    wait_result(cyc);
    checks++; if (cyc !== 17) begin failures++; $display("FAIL empty_latency: got %0d want 17", cyc); end
    checks++; if (empty_count !== 5'd10) begin failures++; $display("FAIL empty_ec: got %0d want 10", empty_count); end
    checks++; if (wrong_count !== 5'd0) begin failures++; $display("FAIL empty_wc: got %0d want 0", wrong_count); end
    checks++; if (incorrect_match !== 1'b1) begin failures++; $display("FAIL empty_im: got %b want 1", incorrect_match); end
    checks++; if (first_wrong_valid !== 1'b0) begin failures++; $display("FAIL empty_fwv: got %b want 0", first_wrong_valid); end
  endtask

  task automatic test_given_cell();
    int cyc;
    user_board = key_board; user_filled = '1; given_mask = '0;
    user_board[2][1] = key_board[2][1] + 2'd2;
    user_filled[2][1] = 1'b0;
    given_mask[2][1] = 1'b1;
    pulse_start();
    wait_result(cyc);
    checks++; if (cyc !== 17) begin failures++; $display("FAIL given_latency: got %0d want 17", cyc); end
    checks++; if (wrong_count !== 5'd0 || empty_count !== 5'd0) begin
      failures++; $display("FAIL given_counts: got wc=%0d ec=%0d want 0/0", wrong_count, empty_count);
    end
    checks++; if (incorrect_match !== 1'b0) begin failures++; $display("FAIL given_im: got %b want 0", incorrect_match); end
  endtask

  task automatic test_clear();
    int pulses = 0;
    int cyc;
    set_two_wrong();
    pulse_start();
    repeat (8) @(posedge clk);
    #1;
    // Cell (1,2) is index 6, processed on the 7th scan edge.
    checks++; if (wrong_count !== 5'd1 || first_wrong_valid !== 1'b1) begin
      failures++; $display("FAIL clear_partial: got wc=%0d fwv=%b want wc=1 fwv=1", wrong_count, first_wrong_valid);
    end
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    checks++;
    if ({busy, result_valid, incorrect_match, wrong_count, empty_count, first_wrong_valid,
         first_wrong_row, first_wrong_col} !== '0) begin
      failures++;
      $display("FAIL clear_outputs: busy=%b rv=%b im=%b wc=%0d ec=%0d fwv=%b row=%0d col=%0d want all 0",
               busy, result_valid, incorrect_match, wrong_count, empty_count, first_wrong_valid,
               first_wrong_row, first_wrong_col);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL clear_no_result: got %0d pulses want 0", pulses); end
    pulse_start();
    wait_result(cyc);
    checks++; if (cyc !== 17) begin failures++; $display("FAIL clear_restart_latency: got %0d want 17", cyc); end
    checks++; if (wrong_count !== 5'd2 || incorrect_match !== 1'b1) begin
      failures++; $display("FAIL clear_restart_result: got wc=%0d im=%b want wc=2 im=1", wrong_count, incorrect_match);
    end
  endtask

  initial begin
    test_reset();
    test_all_correct();
    test_two_wrong();
    test_back_to_back();
    test_all_empty();
    test_given_cell();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sudoku_board_checker.md
Name: sudoku_board_checker

Overview:
- Sequential answer checker that sits directly upstream of the Sudoku game-logic controller and produces its incorrectMatch input.
- On a start pulse it snapshots the player's board, the answer key and the given-cell mask, then scans one cell per clock in row-major order.
- It reports a mismatch flag, wrong/empty cell counts and the first wrong cell for on-screen highlighting.

Parameters:
- N, 4, grid dimension (N x N cells).
- W, 2, bits per cell value (value v encodes digit v+1).
- CW, $clog2(N*N+1), width of the count outputs (5 for N=4).

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort/clear; same effect as reset (driven by the new-game single pulse).
- start  input  1  request a check (single-cycle pulse from the check-response button).
- user_board  input  [W-1:0] x [N-1:0][N-1:0]  player-entered values.
- user_filled  input  [N-1:0][N-1:0]  1 = player has entered a value in that cell.
- key_board  input  [W-1:0] x [N-1:0][N-1:0]  answer key from the game-select block.
- given_mask  input  [N-1:0][N-1:0]  1 = pre-printed cell; always counted correct, never counted empty.
- busy  output  1  high while a scan is in progress.
- result_valid  output  1  one-cycle pulse when the results are final.
- incorrect_match  output  1  result flag; held until the next accepted start, clear or reset.
- wrong_count  output  CW  filled, non-given cells whose value != key.
- empty_count  output  CW  non-given cells with user_filled=0.
- first_wrong_valid  output  1  at least one wrong cell was found.
- first_wrong_row, first_wrong_col  output  $clog2(N) each  coordinates of the lowest-index wrong cell.

Behaviour:
- Reset/clear: state=IDLE; every output 0; the snapshot registers hold don't-care values. Reset and clear take priority over everything, including mid-scan; any partial result is discarded and result_valid is not pulsed.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1:
  - Snapshot all three board inputs on that edge.
  - Zero the counts, first_wrong_valid and incorrect_match.
  - Set idx=0 and go to SCAN.
- SCAN:
  - busy=1; process cell idx (row=idx/N, col=idx%N) from the snapshot each cycle.
  - given: no count change.
  - Not given and not filled: empty_count+1.
  - Filled and value != key: wrong_count+1. If first_wrong_valid is still 0, latch row/col and set it.
  - At idx=N*N-1, go to DONE; otherwise idx+1.
- DONE:
  - result_valid=1 for exactly one cycle; busy=0.
  - incorrect_match = (wrong_count!=0) | (empty_count!=0), registered so it is visible in the same cycle as result_valid.
  - Then go to IDLE.
- Latency: start sampled at edge E0. Cells are processed on edges E1..E16 (N=4). result_valid is high in the cycle following E17.
- start while busy or in DONE is ignored; it is neither queued nor restarted.
- Input changes after the start edge do not affect the current result, because the scan works on the snapshot.
- Counts cannot overflow: the maximum is N*N, which fits in CW.
- Outputs other than result_valid and busy hold their last values in IDLE.

Test Plan:
- Reset then start with user_board == key_board, all cells filled, given_mask=0 → result_valid pulses 17 cycles after start; incorrect_match=0, wrong_count=0, empty_count=0, first_wrong_valid=0.
- Board correct except cells (1,2) and (3,0) set to key+1 mod 4 → wrong_count=2, first_wrong_row=1, first_wrong_col=2, incorrect_match=1.
- All user_filled=0 and given_mask with 6 bits set → empty_count=10, wrong_count=0, incorrect_match=1.
- Given cell with a deliberately wrong user value and user_filled=0 → counted neither wrong nor empty; incorrect_match=0 when all other cells are correct.
- Start pulse during SCAN (cycle 5), plus user_board modified at cycle 3 → single result_valid at cycle 17 reflecting the original snapshot.
- clear asserted at scan cycle 8 → next cycle busy=0 and all outputs 0, no result_valid. A fresh start afterwards completes normally 17 cycles later.
